// File: rtl/a2d_resp_pkg.sv
// Shared definitions for the A2D SPI responder.
//   state_e      : responder FSM states
//   FRM_BITS     : SCLK rises in a complete command frame
//   CH_MSB/LSB   : channel field position inside the 16-bit command
//   DATA_W       : conversion width per channel
//   NUM_CH       : channels packed into chan_val
//   SCLK_MIN_HALF: minimum SCLK high/low time (clk cycles) the
//                  synchronizer path is guaranteed to track
//   LFSR_SEED/TAPS, lfsr_next: conversion-noise generator (used only when
//                  A2D_RESP_NOISE_EN is defined)
package a2d_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  localparam int unsigned FRM_BITS      = 16;
  localparam int unsigned CH_MSB        = 13;
  localparam int unsigned CH_LSB        = 11;
  localparam int unsigned DATA_W        = 12;
  localparam int unsigned NUM_CH        = 8;
  localparam int unsigned SCLK_MIN_HALF = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop.
//   clk, rst : system clock, async active-high reset (all flops clear to 0)
//   din      : asynchronous input pin
//   lvl      : synchronized level
//   rise/fall: one-cycle pulses on synchronized edges
// Clearing to 0 means a line that is high at reset release shows up as a
// rise, and a line that is low shows no edge at all; both are harmless to
// the responder, which only starts a frame on a fall.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign lvl  = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D converter (mode 0).
// Each 16-bit frame carries a channel command in bits [13:11]; the response
// shifted out on MISO is the conversion of the channel commanded in the
// previous complete frame.
//   clk, rst  : system clock, async active-high reset
//   SS_n      : slave select (active low), asynchronous
//   SCLK      : serial clock, asynchronous, idles low
//   MOSI      : command data, MSB first
//   chan_val  : eight 12-bit values, channel n at [12n+11:12n]
//   MISO      : response data, MSB first, 0 when not selected
//   cmd_vld   : one-cycle pulse when a full command has been received
//   cmd_ch    : channel of the last complete command
//   short_frm : one-cycle pulse when SS_n rose before 16 SCLK rises
// Build option: A2D_RESP_NOISE_EN adds LFSR noise to bits [1:0] of the
// returned value; the LFSR advances once per completed frame.
module a2d_spi_resp
  import a2d_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [95:0] chan_val,
  output logic        MISO,
  output logic        cmd_vld,
  output logic [2:0]  cmd_ch,
  output logic        short_frm
);

  localparam logic [4:0] BITS_FULL = 5'(FRM_BITS);

  logic ss_rise, ss_fall, ss_lvl_unused;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge u_sync_ss (
    .clk (clk), .rst (rst), .din (SS_n),
    .lvl (ss_lvl_unused), .rise (ss_rise), .fall (ss_fall)
  );

  spi_sync_edge u_sync_sclk (
    .clk (clk), .rst (rst), .din (SCLK),
    .lvl (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk (clk), .rst (rst), .din (MOSI),
    .lvl (mosi_s), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  state_e      state_q, state_d;
  logic [15:0] tx_shft_q, tx_shft_d;
  logic [15:0] rx_shft_q, rx_shft_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  ch_prev_q, ch_prev_d;
  logic [2:0]  cmd_ch_q, cmd_ch_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        short_frm_q, short_frm_d;
  logic        miso_q, miso_d;
  logic        pend_q, pend_d;
  logic [DATA_W-1:0] sample;
`ifdef A2D_RESP_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    state_d     = state_q;
    tx_shft_d   = tx_shft_q;
    rx_shft_d   = rx_shft_q;
    bit_cnt_d   = bit_cnt_q;
    ch_prev_d   = ch_prev_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_vld_d   = 1'b0;
    short_frm_d = 1'b0;
    pend_d      = 1'b0;
`ifdef A2D_RESP_NOISE_EN
    lfsr_d      = lfsr_q;
`endif

    sample = chan_val[32'(ch_prev_q) * DATA_W +: DATA_W];
`ifdef A2D_RESP_NOISE_EN
    sample[1:0] = sample[1:0] ^ lfsr_q[1:0];
`endif

    unique case (state_q)
      IDLE: begin
        // pend_q carries an SS_n fall that arrived during DONE
        if (ss_fall || pend_q) begin
          state_d   = XFER;
          tx_shft_d = {4'h0, sample};
          bit_cnt_d = '0;
        end
      end
      XFER: begin
        if (ss_rise) begin
          if (bit_cnt_q == BITS_FULL) begin
            state_d = DONE;
          end else begin
            short_frm_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          if (sclk_rise && bit_cnt_q < BITS_FULL) begin
            rx_shft_d = {rx_shft_q[14:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sclk_fall && bit_cnt_q < BITS_FULL) begin
            tx_shft_d = {tx_shft_q[14:0], 1'b0};
          end
        end
      end
      DONE: begin
        cmd_ch_d  = rx_shft_q[CH_MSB:CH_LSB];
        ch_prev_d = rx_shft_q[CH_MSB:CH_LSB];
        cmd_vld_d = 1'b1;
        pend_d    = ss_fall;
        state_d   = IDLE;
`ifdef A2D_RESP_NOISE_EN
        lfsr_d    = lfsr_next(lfsr_q);
`endif
      end
      default: state_d = IDLE;
    endcase

    // Once all 16 bits have been taken MISO drops to 0 so extra SCLK
    // pulses clock out zeros rather than repeating the last data bit.
    miso_d = (state_d == XFER && bit_cnt_d < BITS_FULL) ? tx_shft_d[15] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shft_q   <= '0;
      rx_shft_q   <= '0;
      bit_cnt_q   <= '0;
      ch_prev_q   <= '0;
      cmd_ch_q    <= '0;
      cmd_vld_q   <= 1'b0;
      short_frm_q <= 1'b0;
      miso_q      <= 1'b0;
      pend_q      <= 1'b0;
`ifdef A2D_RESP_NOISE_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      tx_shft_q   <= tx_shft_d;
      rx_shft_q   <= rx_shft_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_prev_q   <= ch_prev_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_vld_q   <= cmd_vld_d;
      short_frm_q <= short_frm_d;
      miso_q      <= miso_d;
      pend_q      <= pend_d;
`ifdef A2D_RESP_NOISE_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign MISO      = miso_q;
  assign cmd_vld   = cmd_vld_q;
  assign cmd_ch    = cmd_ch_q;
  assign short_frm = short_frm_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic [95:0] chan_val = '0;
  logic        MISO;
  logic        cmd_vld;
  logic [2:0]  cmd_ch;
  logic        short_frm;

  a2d_spi_resp u_dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .chan_val  (chan_val),
    .MISO      (MISO),
    .cmd_vld   (cmd_vld),
    .cmd_ch    (cmd_ch),
    .short_frm (short_frm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: converter channel contents, last command, noise source.
  logic [11:0] chan_m [8];
  int          ch_prev_m = 0;
  int          cmd_ch_m  = 0;
  logic [15:0] lfsr_m    = 16'hACE1;

  typedef struct {
    bit         is_short;
    logic [2:0] ch;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_chan(input int i, input logic [11:0] v);
    chan_m[i] = v;
    chan_val[i*12 +: 12] = v;
  endtask

  // One master transaction: nrise SCLK pulses, half period 5 clk.
  task automatic frame(input logic [15:0] cmd, input int nrise, input int gap);
    logic [11:0] v;
    logic [15:0] resp;
    logic        exp_bit;
    ev_t         ev;
    v = chan_m[ch_prev_m];
`ifdef A2D_RESP_NOISE_EN
    v[1:0] = v[1:0] ^ lfsr_m[1:0];
`endif
    resp = {4'h0, v};
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = cmd[15];
    wait_clk(6);
    for (int i = 0; i < nrise; i++) begin
      exp_bit = (i < 16) ? resp[15-i] : 1'b0;
      check($sformatf("miso_bit%0d", i), {31'd0, MISO}, {31'd0, exp_bit});
      SCLK = 1'b1;
      wait_clk(5);
      SCLK = 1'b0;
      MOSI = (i + 1 < 16) ? cmd[14-i] : 1'($urandom);
      // change a channel mid-frame: must not affect the frame in flight
      if (i == 3) set_chan(int'($urandom_range(0, 7)), 12'($urandom));
      wait_clk(5);
    end
    if (nrise >= 16) begin
      ev.is_short = 1'b0;
      ev.ch       = cmd[13:11];
      ch_prev_m   = int'(cmd[13:11]);
      cmd_ch_m    = int'(cmd[13:11]);
      lfsr_m      = ref_lfsr(lfsr_m);
    end else begin
      ev.is_short = 1'b1;
      ev.ch       = 3'(cmd_ch_m);
    end
    exp_q.push_back(ev);
    SS_n = 1'b1;
    wait_clk(gap);
  endtask

  // Monitor: every cmd_vld / short_frm pulse is matched against the queue.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst && (cmd_vld || short_frm)) begin
        check("pulse_exclusive", {31'd0, cmd_vld & short_frm}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, cmd_vld, short_frm}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind", {31'd0, short_frm}, {31'd0, ev.is_short});
          check("cmd_ch", {29'd0, cmd_ch}, {29'd0, ev.ch});
        end
      end
    end
  end

  initial begin
    logic [15:0] cmd;
    int          n;
    for (int i = 0; i < 8; i++) set_chan(i, 12'($urandom));
    wait_clk(3);
    #1;
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    check("rst_short_frm", {31'd0, short_frm}, 32'd0);
    check("rst_cmd_ch", {29'd0, cmd_ch}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(4);

    // directed frames
    set_chan(0, 12'h800);
    frame(16'h2000, 16, 6);          // returns ch0, commands ch4
    set_chan(4, 12'hABC);
    frame(16'h0000, 16, 6);          // returns ch4, commands ch0
    frame(16'h2000, 16, 6);          // commands ch4 again
    frame(16'h0800, 9, 6);           // aborted: short_frm, ch4 kept
    frame(16'h1800, 16, 6);          // still returns ch4, commands ch3
    frame(16'h3FFF, 20, 6);          // extra clocks, commands ch7

    // reset in the middle of a frame
    wait_clk(4);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b1;
    wait_clk(6);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b1; wait_clk(5);
      SCLK = 1'b0; wait_clk(5);
    end
    rst = 1'b1;
    #1;
    check("midrst_miso", {31'd0, MISO}, 32'd0);
    check("midrst_cmd_ch", {29'd0, cmd_ch}, 32'd0);
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    exp_q.delete();
    ch_prev_m = 0;
    cmd_ch_m  = 0;
    lfsr_m    = 16'hACE1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    frame(16'h2800, 16, 6);          // returns ch0 after reset

    // randomized frames, including back-to-back ones
    for (int k = 0; k < 30; k++) begin
      cmd = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       n = int'($urandom_range(1, 15));
        1:       n = int'($urandom_range(17, 20));
        default: n = 16;
      endcase
      frame(cmd, n, int'($urandom_range(1, 6)));
    end

    // constant input: only noise (when enabled) may alter bits [1:0]
    for (int i = 0; i < 8; i++) set_chan(i, 12'h400);
    for (int k = 0; k < 8; k++) begin
      frame({2'b00, 3'(k), 11'($urandom)}, 16, 6);
      for (int i = 0; i < 8; i++) set_chan(i, 12'h400);
    end

    wait_clk(12);
    check("events_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder that emulates the 8-channel, 12-bit A2D converter on the far end of the A2D serial link (SS_n/SCLK/MOSI in, MISO out). It decodes the channel command in each 16-bit frame and returns the conversion of the previously commanded channel on the next frame. It is used in the full-chip bench and on the FPGA self-test build in place of the real converter; channel values (load cells, battery) are driven by the bench or a stimulus block.

## Interface
- SCLK_MIN_HALF, 4: minimum SCLK high/low time in clk cycles that the block is guaranteed to track.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  slave select from master, active low; asynchronous to clk.
- SCLK  input  1  serial clock from master (mode 0: idles low); asynchronous to clk.
- MOSI  input  1  serial command from master, MSB first.
- chan_val  input  96  eight 12-bit conversion values, channel n at bits [12n+11:12n].
- MISO  output  1  serial response, MSB first; driven 0 when not selected (no tristate).
- cmd_vld  output  1  one-cycle pulse: a complete 16-bit command was received.
- cmd_ch  output  3  channel decoded from the last complete command.
- short_frm  output  1  one-cycle pulse: SS_n deasserted before 16 SCLK rises.

## Operation
- SS_n, SCLK, MOSI each pass through two flops (metastability), then one edge-detect flop. Internal events: ss_fall, ss_rise, sclk_rise, sclk_fall.
- States: IDLE, XFER, DONE.
- IDLE: on ss_fall -> XFER; snapshot tx_shft = {4'h0, chan_val[ch_prev]}; bit_cnt = 0.
- XFER: sclk_rise -> rx_shft = {rx_shft[14:0], MOSI_sync}, bit_cnt++ (saturates at 16). sclk_fall -> tx_shft shifts left, 0 in, only while bit_cnt < 16. MISO = tx_shft[15] while selected.
- XFER, ss_rise: bit_cnt == 16 -> DONE; else short_frm pulse, return to IDLE, ch_prev/cmd_ch unchanged.
- DONE (one cycle): cmd_ch = rx_shft[13:11], ch_prev = rx_shft[13:11], cmd_vld = 1; -> IDLE.
- Command bits other than [13:11] are ignored.
- SCLK edges beyond the 16th are ignored; MISO holds 0 after bit 15.
- ss_fall while in XFER (glitch/missed rise) is impossible by construction; ss_fall in DONE is taken in the following IDLE cycle (edge held one cycle).
- chan_val changes mid-frame do not affect the frame in flight.

## Timing
- Reset values: MISO 0, cmd_vld 0, short_frm 0, cmd_ch 0, ch_prev 0, state IDLE, shift registers 0. First frame after reset returns chan_val channel 0.
- Reset asserted mid-frame aborts immediately. Frame is ignored until the next ss_fall after reset release.
- SCLK high and low must each last >= SCLK_MIN_HALF clk cycles; SS_n setup to first SCLK rise >= 4 clk.
- MISO bit 15 valid 3 clk after SS_n falls; each following bit valid 3 clk after the SCLK fall (master samples on the next rise).
- cmd_vld rises 4 clk after the SS_n rise pin edge (3 sync/edge + DONE); short_frm 3 clk after it.
- Frame-to-frame latency: response data is always one frame behind the command.

## Configuration
- A2D_RESP_NOISE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances once per completed frame. Its two LSBs are XORed into bits [1:0] of the 12-bit value at snapshot, emulating conversion noise.
- Undefined: no LFSR; returned value equals chan_val exactly.

## Structure
- Package a2d_resp_pkg: state enum (IDLE, XFER, DONE), FRM_BITS = 16, CH_MSB = 13, CH_LSB = 11, DATA_W = 12, NUM_CH = 8, LFSR seed/taps.
- Sub-module spi_sync_edge: 2-flop synchronizer plus edge detect, instantiated three times (SS_n, SCLK, MOSI; MOSI uses only the synchronized level).

## Test plan
- Reset, chan_val ch0 = 12'h800. One 16-bit frame with cmd 16'h2000 (ch4) -> MISO shifts 16'h0800, cmd_vld pulse, cmd_ch = 4.
- chan_val ch4 = 12'hABC. Next frame with cmd 16'h0000 -> MISO returns 16'h0ABC, cmd_ch = 0.
- Frame aborted after 9 SCLK rises -> short_frm pulse, no cmd_vld, cmd_ch holds 4. Next full frame still returns channel 4 data.
- 20 SCLK pulses in one frame -> first 16 bits correct, bits 17-20 MISO = 0, cmd decoded from first 16 bits.
- Assert rst at bit 8 of a frame -> MISO 0 immediately, cmd_ch 0. Next clean frame returns channel 0 data.
- With A2D_RESP_NOISE_EN, constant 12'h400 over 8 frames -> returned values differ from 12'h400 only in bits [1:0] and match a reference LFSR sequence.
